// File: rtl/gpio_stream_pkg.sv
// Shared types and constants for the GPIO frame-dump scheduler.
// The optional prefetch build is selected with the GPIO_STREAM_PREFETCH_EN macro.
package gpio_stream_pkg;

  localparam int DEF_DATA_W = 128;
  localparam int DEF_GPIO_W = 32;
  localparam int LANES      = DEF_DATA_W / DEF_GPIO_W;
  localparam int LANE_W     = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/vec_serializer.sv
// Holds one DATA_W vector and emits it as GPIO_W words, lane 0 first,
// under a valid/ready handshake. A load takes priority over the shift, so a
// new vector may be loaded in the same cycle the last lane is accepted.
module vec_serializer
  import gpio_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GPIO_W = DEF_GPIO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              gpio_ready,
  output logic [GPIO_W-1:0] gpio_data,
  output logic [LANE_W-1:0] gpio_lane,
  output logic              gpio_valid,
  output logic              last_acc
);

  localparam int NL = DATA_W / GPIO_W;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NL - 1);

  logic [DATA_W-1:0] shift_reg;
  logic [LANE_W-1:0] lane_reg;
  logic              valid_reg;
  logic              acc;

  assign acc        = valid_reg & gpio_ready;
  assign last_acc   = acc & (lane_reg == LAST_LANE);
  assign gpio_data  = shift_reg[GPIO_W-1:0];
  assign gpio_lane  = lane_reg;
  assign gpio_valid = valid_reg;

  // Load a new vector, or shift one lane out per accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      lane_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      lane_reg  <= '0;
      valid_reg <= 1'b1;
    end else if (acc) begin
      if (lane_reg == LAST_LANE) begin
        shift_reg <= '0;
        lane_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        shift_reg <= shift_reg >> GPIO_W;
        lane_reg  <= lane_reg + LANE_W'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_stream_sched.sv
// Shares the single-port vector memory between the pipeline (absolute
// priority) and a frame-dump engine that streams vectors out over GPIO.
// Define GPIO_STREAM_PREFETCH_EN to add a second vector buffer so the next
// read overlaps the current SEND; the port list is the same in both builds.
module gpio_stream_sched
  import gpio_stream_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GPIO_W = DEF_GPIO_W,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [GPIO_W-1:0] gpio_data,
  output logic [1:0]        gpio_lane,
  output logic              gpio_valid,
  input  logic              gpio_ready,
  output logic              busy,
  output logic              done
);

  state_t            state_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0]  fetch_left_reg;   // reads still to issue
  logic [CNT_W-1:0]  send_left_reg;    // vectors still to stream out
  logic              done_reg;

  logic              issue;
  logic              ser_load;
  logic [DATA_W-1:0] ser_data;
  logic              last_acc;
  logic              last_vec;

`ifdef GPIO_STREAM_PREFETCH_EN
  logic [DATA_W-1:0] pf_buf_reg;
  logic              pf_full_reg;
  logic              rd_pending_reg;   // read data arrives this cycle
`endif

  assign last_vec = (send_left_reg == CNT_W'(1));

  // Decide when the dump engine reads and what the serializer loads.
  always_comb begin
    issue    = 1'b0;
    ser_load = 1'b0;
    ser_data = mem_rdata;
`ifdef GPIO_STREAM_PREFETCH_EN
    issue    = !pipe_req && (fetch_left_reg != '0) &&
               ((state_reg == FETCH) ||
                ((state_reg == SEND) && !pf_full_reg && !rd_pending_reg));
    ser_load = (state_reg == WAIT) ||
               ((state_reg == SEND) && last_acc && !last_vec &&
                (pf_full_reg || rd_pending_reg));
    ser_data = pf_full_reg ? pf_buf_reg : mem_rdata;
`else
    issue    = !pipe_req && (fetch_left_reg != '0) && (state_reg == FETCH);
    ser_load = (state_reg == WAIT);
`endif
  end

  // Memory port mux: the pipeline always wins, the dump reads in free cycles.
  always_comb begin
    mem_en    = pipe_req | issue;
    mem_we    = pipe_req & pipe_we;
    mem_addr  = pipe_req ? pipe_addr : rd_ptr_reg;
    mem_wdata = pipe_req ? pipe_wdata : '0;
  end

  assign pipe_rdata = mem_rdata;
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;

  // Dump sequencer: state, read pointer, vector counters and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      rd_ptr_reg     <= '0;
      fetch_left_reg <= '0;
      send_left_reg  <= '0;
      done_reg       <= 1'b0;
`ifdef GPIO_STREAM_PREFETCH_EN
      pf_buf_reg     <= '0;
      pf_full_reg    <= 1'b0;
      rd_pending_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (issue) begin
        rd_ptr_reg     <= rd_ptr_reg + ADDR_W'(1);
        fetch_left_reg <= fetch_left_reg - CNT_W'(1);
      end
`ifdef GPIO_STREAM_PREFETCH_EN
      rd_pending_reg <= issue;
      if ((state_reg == SEND) && rd_pending_reg && !ser_load) begin
        pf_buf_reg  <= mem_rdata;
        pf_full_reg <= 1'b1;
      end else if (ser_load && pf_full_reg) begin
        pf_full_reg <= 1'b0;
      end
`endif
      case (state_reg)
        IDLE: begin
          if (start) begin
            rd_ptr_reg     <= base_addr;
            fetch_left_reg <= num_vec;
            send_left_reg  <= num_vec;
            state_reg      <= (num_vec == '0) ? DONE : FETCH;
          end
        end
        FETCH: if (issue) state_reg <= WAIT;
        WAIT:  state_reg <= SEND;
        SEND: begin
          if (last_acc) begin
            send_left_reg <= send_left_reg - CNT_W'(1);
            if (last_vec)      state_reg <= DONE;
            else if (ser_load) state_reg <= SEND;
            else if (issue)    state_reg <= WAIT;
            else               state_reg <= FETCH;
          end
        end
        DONE: begin
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  vec_serializer #(
    .DATA_W (DATA_W),
    .GPIO_W (GPIO_W)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (ser_load),
    .load_data  (ser_data),
    .gpio_ready (gpio_ready),
    .gpio_data  (gpio_data),
    .gpio_lane  (gpio_lane),
    .gpio_valid (gpio_valid),
    .last_acc   (last_acc)
  );

endmodule
